// File: rtl/if_stage.sv
// Instruction fetch front end: owns the PC, fetches one word at a time, presents it to decode.
// Latency: imem_req 1 cycle after reset release; inst_valid the cycle after imem_rvalid.
// Backpressure: the fetched word is held while inst_ready is low; no new request is issued until it is taken.
module if_stage #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [WORD_WIDTH-1:0] inst_code,
    output logic [WORD_WIDTH-1:0] inst_pc,
    output logic [WORD_WIDTH-1:0] inst_pc4,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_pc,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [WORD_WIDTH-1:0] PC_STEP   = WORD_WIDTH'(4);
    // The low two bits of RESET_PC are forced to zero so the PC is always word aligned.
    localparam logic [WORD_WIDTH-1:0] RESET_ALN = {RESET_PC[WORD_WIDTH-1:2], 2'b00};

    state_t                state;
    state_t                nextState;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] nextPc;
    logic                  kill;
    logic                  nextKill;
    logic                  latchInst;
    logic                  countInc;
    logic [WORD_WIDTH-1:0] redirectTarget;
    logic [WORD_WIDTH-1:0] instCode;
    logic [WORD_WIDTH-1:0] instPc;
    logic [31:0]           fetchCount;

    // Redirect targets are word aligned; the byte-offset bits are simply dropped.
    logic unusedRedirectBits;
    assign unusedRedirectBits = ^redirect_pc[1:0];
    assign redirectTarget     = {redirect_pc[WORD_WIDTH-1:2], 2'b00};

    // State, PC, kill flag, output word register and accept counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_ALN;
            kill       <= 1'b0;
            instCode   <= '0;
            instPc     <= '0;
            fetchCount <= '0;
        end else begin
            state <= nextState;
            pc    <= nextPc;
            kill  <= nextKill;
            if (latchInst) begin
                instCode <= imem_rdata;
                instPc   <= pc;
            end
            if (countInc) begin
                fetchCount <= fetchCount + 32'd1;
            end
        end
    end

    // Next-state logic; a redirect overrides every other event in the same cycle.
    always_comb begin
        nextState = state;
        nextPc    = pc;
        nextKill  = kill;
        latchInst = 1'b0;
        countInc  = 1'b0;

        unique case (state)
            IDLE: begin
                nextState = REQ;
                if (redirect_valid) begin
                    nextPc = redirectTarget;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    nextPc = redirectTarget;
                    // A request granted in the same cycle is already in flight;
                    // its response must be thrown away when it arrives.
                    if (imem_gnt) begin
                        nextKill  = 1'b1;
                        nextState = WAIT;
                    end
                end else if (imem_gnt) begin
                    nextState = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    nextPc = redirectTarget;
                    if (imem_rvalid) begin
                        // Response arrives with the redirect: drop it and refetch now.
                        nextKill  = 1'b0;
                        nextState = REQ;
                    end else begin
                        nextKill = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill) begin
                        nextKill  = 1'b0;
                        nextState = REQ;
                    end else begin
                        latchInst = 1'b1;
                        nextState = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    // The held word is discarded and never counted as consumed.
                    nextPc    = redirectTarget;
                    nextState = REQ;
                end else if (inst_ready) begin
                    nextPc    = pc + PC_STEP;
                    countInc  = 1'b1;
                    nextState = REQ;
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = (state == REQ) ? pc : '0;
    assign inst_valid  = (state == HOLD);
    assign inst_code   = instCode;
    assign inst_pc     = instPc;
    assign inst_pc4    = instPc + PC_STEP;
    assign fetch_count = fetchCount;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small instruction-memory responder.
// Memory returns addr ^ 32'hA5A5_0000, rvDelay cycles after the grant cycle.
// Checks are taken on the falling edge; inputs change 1 ns after the rising edge.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    if_stage #(.WORD_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_code     (inst_code),
        .inst_pc       (inst_pc),
        .inst_pc4      (inst_pc4),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder state.
    int          rvDelay    = 1;
    int          pendCnt    = 0;
    logic [31:0] pendAddr   = '0;
    logic        grantSeen  = 1'b0;
    logic [31:0] grantAddr  = '0;
    logic        rstLow     = 1'b1;
    int          grantCount = 0;

    // Capture the request/grant that the DUT will act on at the next rising edge.
    always @(negedge clk) begin
        grantSeen = imem_req && imem_gnt;
        grantAddr = imem_addr;
        rstLow    = !rst_n;
    end

    // Drive the response rvDelay cycles after the grant cycle, for exactly one cycle.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (rstLow) begin
            pendCnt = 0;
        end else begin
            if (grantSeen) begin
                grantCount = grantCount + 1;
                pendAddr   = grantAddr;
                pendCnt    = rvDelay;
            end
            if (pendCnt > 0) begin
                pendCnt = pendCnt - 1;
                if (pendCnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pendAddr ^ 32'hA5A5_0000;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int gSnap;

    initial begin
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        rst_n          = 1'b0;
        imem_gnt       = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_addr",  imem_addr,           32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_code",  inst_code,           32'd0);
        chk("rst_pc",    inst_pc,             32'd0);
        chk("rst_pc4",   inst_pc4,            32'd4);
        chk("rst_cnt",   fetch_count,         32'd0);

        // c0: release reset, IDLE.
        adv(1); rst_n = 1'b1;
        @(negedge clk); chk("c0_req", {31'b0, imem_req}, 32'd0);
        // c1: first request.
        adv(1); @(negedge clk);
        chk("c1_req",  {31'b0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr,         32'h0);
        // c2: WAIT.
        adv(1); @(negedge clk);
        chk("c2_req",   {31'b0, imem_req},   32'd0);
        chk("c2_valid", {31'b0, inst_valid}, 32'd0);
        // c3: HOLD with first word.
        adv(1); @(negedge clk);
        chk("c3_valid", {31'b0, inst_valid}, 32'd1);
        chk("c3_code",  inst_code,           32'hA5A5_0000);
        chk("c3_pc",    inst_pc,             32'h0);
        chk("c3_pc4",   inst_pc4,            32'h4);
        chk("c3_cnt",   fetch_count,         32'd0);
        // c4: next request.
        adv(1); @(negedge clk);
        chk("c4_addr",  imem_addr,           32'h4);
        chk("c4_cnt",   fetch_count,         32'd1);
        chk("c4_valid", {31'b0, inst_valid}, 32'd0);
        // c6: second word.
        adv(2); @(negedge clk);
        chk("c6_code", inst_code, 32'hA5A5_0004);
        chk("c6_pc",   inst_pc,   32'h4);
        // c7: third request; c8 withdraw ready.
        adv(1); @(negedge clk);
        chk("c7_addr", imem_addr,   32'h8);
        chk("c7_cnt",  fetch_count, 32'd2);
        adv(1); inst_ready = 1'b0;
        // c9..c14: HOLD stalled at pc 8.
        adv(1); @(negedge clk);
        chk("c9_code", inst_code, 32'hA5A5_0008);
        chk("c9_pc",   inst_pc,   32'h8);
        for (int i = 0; i < 5; i++) begin
            adv(1); @(negedge clk);
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("stall_code",  inst_code,           32'hA5A5_0008);
            chk("stall_pc",    inst_pc,             32'h8);
            chk("stall_req",   {31'b0, imem_req},   32'd0);
            chk("stall_cnt",   fetch_count,         32'd2);
        end
        // c15: single ready pulse.
        adv(1); inst_ready = 1'b1;
        // c16: REQ at 12; make the response take 3 cycles.
        adv(1); rvDelay = 3;
        @(negedge clk);
        chk("c16_addr", imem_addr,   32'hC);
        chk("c16_cnt",  fetch_count, 32'd3);
        // c17: WAIT, redirect to 0x43.
        adv(1); redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        @(negedge clk); chk("c17_req", {31'b0, imem_req}, 32'd0);
        adv(1); redirect_valid = 1'b0;
        @(negedge clk); chk("c18_valid", {31'b0, inst_valid}, 32'd0);
        // c19: stale response arrives and is dropped.
        adv(1); @(negedge clk);
        chk("c19_valid", {31'b0, inst_valid}, 32'd0);
        chk("c19_req",   {31'b0, imem_req},   32'd0);
        // c20: refetch at 0x40.
        adv(1); rvDelay = 1;
        @(negedge clk);
        chk("c20_req",   {31'b0, imem_req},   32'd1);
        chk("c20_addr",  imem_addr,           32'h40);
        chk("c20_valid", {31'b0, inst_valid}, 32'd0);
        adv(2); @(negedge clk);
        chk("c22_valid", {31'b0, inst_valid}, 32'd1);
        chk("c22_pc",    inst_pc,             32'h40);
        chk("c22_code",  inst_code,           32'hA5A5_0040);
        chk("c22_cnt",   fetch_count,         32'd3);
        // c23..c25: fetch 0x44, redirect in HOLD together with ready.
        adv(1); @(negedge clk); chk("c23_addr", imem_addr, 32'h44);
        adv(2); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("c25_pc",  inst_pc,     32'h44);
        chk("c25_cnt", fetch_count, 32'd4);
        // c26: instruction dropped, not counted; withhold grant.
        adv(1); redirect_valid = 1'b0; imem_gnt = 1'b0;
        @(negedge clk);
        chk("c26_valid", {31'b0, inst_valid}, 32'd0);
        chk("c26_cnt",   fetch_count,         32'd4);
        chk("c26_addr",  imem_addr,           32'h200);
        gSnap = grantCount;
        // c27: redirect to 0x100 while ungranted.
        adv(1); redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk); chk("c27_addr", imem_addr, 32'h200);
        adv(1); redirect_valid = 1'b0;
        @(negedge clk);
        chk("c28_addr", imem_addr,         32'h100);
        chk("c28_req",  {31'b0, imem_req}, 32'd1);
        adv(1); @(negedge clk); chk("c29_addr", imem_addr, 32'h100);
        adv(1); imem_gnt = 1'b1;
        @(negedge clk); chk("c30_addr", imem_addr, 32'h100);
        adv(2); @(negedge clk);
        chk("c32_pc",     inst_pc,    32'h100);
        chk("c32_code",   inst_code,  32'hA5A5_0100);
        chk("c32_grants", grantCount, gSnap + 1);
        // c33: REQ at 0x104 with redirect to 0xFFFFFFFF (granted same cycle).
        adv(1); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("c33_addr", imem_addr,   32'h104);
        chk("c33_cnt",  fetch_count, 32'd5);
        adv(1); redirect_valid = 1'b0;
        @(negedge clk); chk("c34_valid", {31'b0, inst_valid}, 32'd0);
        adv(1); @(negedge clk); chk("c35_addr", imem_addr, 32'hFFFF_FFFC);
        adv(2); @(negedge clk);
        chk("c37_pc",   inst_pc,   32'hFFFF_FFFC);
        chk("c37_pc4",  inst_pc4,  32'h0);
        chk("c37_code", inst_code, 32'h5A5A_FFFC);
        adv(1); rvDelay = 5;
        @(negedge clk);
        chk("c38_addr", imem_addr,   32'h0);
        chk("c38_cnt",  fetch_count, 32'd6);
        // c39: reset pulse in WAIT, outputs return at once.
        adv(1); rst_n = 1'b0;
        #1;
        chk("mid_req",   {31'b0, imem_req},   32'd0);
        chk("mid_valid", {31'b0, inst_valid}, 32'd0);
        chk("mid_code",  inst_code,           32'd0);
        chk("mid_pc",    inst_pc,             32'd0);
        chk("mid_pc4",   inst_pc4,            32'd4);
        chk("mid_cnt",   fetch_count,         32'd0);
        adv(1); rst_n = 1'b1; rvDelay = 1;
        adv(1); @(negedge clk);
        chk("rr_req",  {31'b0, imem_req}, 32'd1);
        chk("rr_addr", imem_addr,         32'h0);
        adv(2); @(negedge clk);
        chk("rr_valid", {31'b0, inst_valid}, 32'd1);
        chk("rr_code",  inst_code,           32'hA5A5_0000);
        chk("rr_cnt",   fetch_count,         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch front end that sits directly upstream of the single-cycle datapath's decode/execute logic.
- Owns the program counter.
- Issues word requests to an instruction memory with variable latency.
- Holds each fetched word in an output register, with a valid/ready handshake toward the consumer.
- Accepts branch/jump redirects from downstream and discards any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
WORD_WIDTH, 32, instruction and address width.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request valid.
imem_addr  output  WORD_WIDTH  byte address of the requested word; bits [1:0] are always 0.
imem_gnt  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  response data valid; only sent for granted requests, in order.
imem_rdata  input  WORD_WIDTH  instruction word.
inst_valid  output  1  inst_code is valid.
inst_ready  input  1  consumer takes the instruction this cycle.
inst_code  output  WORD_WIDTH  fetched instruction.
inst_pc  output  WORD_WIDTH  address of inst_code.
inst_pc4  output  WORD_WIDTH  inst_pc + 4, for link writes.
redirect_valid  input  1  take redirect_pc as the next fetch address.
redirect_pc  input  WORD_WIDTH  target; bits [1:0] are ignored (treated as 0).
fetch_count  output  32  number of instructions accepted by the consumer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; state = IDLE; kill = 0.
  - imem_req = 0; inst_valid = 0; inst_code/inst_pc = 0; inst_pc4 = 4; fetch_count = 0.
- imem_req = 1 only in REQ; imem_addr = pc in REQ, else 0.
- States and transitions:
  - IDLE: go to REQ on the next edge, unconditionally.
  - REQ: hold imem_req and imem_addr stable until imem_gnt; on gnt go to WAIT.
  - WAIT: on imem_rvalid:
    - if kill: discard the data, clear kill, go to REQ;
    - else: latch inst_code = imem_rdata and inst_pc = pc, go to HOLD.
  - HOLD: inst_valid = 1. On inst_ready: pc = pc + 4, fetch_count += 1, go to REQ.
- At most one request outstanding.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD) when gnt and rvalid each come one cycle after their trigger.
- Latency: first imem_req is asserted 1 cycle after reset release; inst_valid rises in the cycle after the rvalid cycle.
- Redirect (redirect_valid = 1) has priority over every other event in the same cycle. The next pc is {redirect_pc[31:2], 2'b00}.
  - IDLE: pc updated; still goes to REQ.
  - REQ without gnt: pc updated; stay in REQ; imem_addr shows the new pc next cycle.
  - REQ with gnt: the old request is in flight; set kill; go to WAIT.
  - WAIT without rvalid: set kill.
  - WAIT with rvalid: discard the data; go to REQ (kill stays 0).
  - HOLD: drop the instruction; inst_valid = 0 next cycle; go to REQ. Even if inst_ready is high that cycle, fetch_count does not increment and the instruction is not considered consumed.
- Arithmetic:
  - pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - inst_pc4 = inst_pc + 4 with the same wrap.
  - fetch_count wraps at 2^32.
- inst_code, inst_pc and inst_pc4 stay stable while inst_valid = 1 and inst_ready = 0.
- imem_rvalid outside WAIT is a protocol error and is ignored; state is unchanged.
- Reset asserted mid-operation:
  - immediately returns all outputs to their reset values;
  - any response from a pre-reset request is the memory's responsibility and must not arrive after reset.

Test Plan:
- Reset release with RESET_PC = 0, gnt tied 1, memory returning rdata = addr ^ 32'hA5A5_0000 one cycle after grant, inst_ready = 1 → imem_addr sequence 0, 4, 8; inst_pc 0/4/8 with inst_code 32'hA5A5_0000/32'hA5A5_0004/32'hA5A5_0008; fetch_count = 3 after the third accept.
- inst_ready held 0 for 5 cycles while in HOLD at pc = 8 → inst_valid stays 1, inst_code/inst_pc stay stable, imem_req stays 0, fetch_count unchanged; then one ready pulse → next imem_addr = 12.
- Redirect to 32'h0000_0043 during WAIT, with rvalid 2 cycles later → that response is discarded (inst_valid stays 0); next imem_addr = 32'h40; its data is delivered with inst_pc = 32'h40.
- Redirect in HOLD at the same cycle as inst_ready = 1 → fetch_count unchanged; inst_valid = 0 next cycle; next imem_addr = redirect target.
- imem_gnt withheld 4 cycles while redirect to 32'h100 arrives in cycle 2 → imem_addr changes to 32'h100 the next cycle and is stable until gnt; only one grant is issued.
- Redirect to 32'hFFFF_FFFC followed by an accept → next imem_addr = 0; inst_pc4 of that instruction = 0; rst_n pulsed low mid-WAIT → outputs at reset values in the same cycle, fetch restarts at RESET_PC.
